// File: rtl/ct_pmp_pkg.sv
// Shared definitions for the PMP check scheduler: write-sequencer state
// encoding and default datapath widths.
package ct_pmp_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned PA_W_DEF  = 28;
  localparam int unsigned FLG_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_WRITE  = 2'b10,
    ST_SETTLE = 2'b11
  } wr_state_e;

endpackage

// File: rtl/ct_pmp_rr_arb.sv
// Round-robin arbiter: grants the first request at or after the pointer and
// advances the pointer past the winner; the pointer holds when nothing is granted.
module ct_pmp_rr_arb #(
  parameter int unsigned NREQ = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_gnt
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_nxt_ptr;
  logic          w_hit;
  int unsigned   w_idx;

  always_comb begin
    o_gnt     = '0;
    w_nxt_ptr = r_ptr;
    w_hit     = 1'b0;
    w_idx     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = (32'(r_ptr) + k) % NREQ;
      if (!w_hit && i_en && i_req[PW'(w_idx)]) begin
        o_gnt[PW'(w_idx)] = 1'b1;
        w_hit             = 1'b1;
        w_nxt_ptr         = PW'((w_idx + 1) % NREQ);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (w_hit) begin
      r_ptr <= w_nxt_ptr;
    end
  end

endmodule

// File: rtl/ct_pmp_chk_sched.sv
// Shares one ct_pmp_acc lookup among NREQ requesters through a 2-stage check
// pipeline, and fences CP0 PMP CSR writes so no check sees a partial update.
module ct_pmp_chk_sched
  import ct_pmp_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned PA_W  = PA_W_DEF,
  parameter int unsigned FLG_W = FLG_W_DEF
) (
  input  logic               forever_cpuclk,
  input  logic               cpurst,
  input  logic [NREQ-1:0]    req_vld,
  input  logic [NREQ*PA_W-1:0] req_pa,
  input  logic [NREQ-1:0]    req_mprv,
  output logic [NREQ-1:0]    req_gnt,
  output logic [NREQ-1:0]    rsp_vld,
  output logic [FLG_W-1:0]   rsp_flg,
  output logic [PA_W-1:0]    acc_pa,
  output logic               acc_mprv_status,
  input  logic [FLG_W-1:0]   acc_flg,
  input  logic               cp0_pmp_wreq,
  output logic               pmp_cp0_wgnt
);

  wr_state_e r_state;
  wr_state_e w_nxt_state;

  logic            w_arb_en;
  logic [NREQ-1:0] w_gnt;
  logic [PA_W-1:0] w_gnt_pa;
  logic            w_gnt_mprv;

  logic            r_s1_vld;
  logic [NREQ-1:0] r_s1_tag;
  logic [PA_W-1:0] r_s1_pa;
  logic            r_s1_mprv;

  logic             r_s2_vld;
  logic [NREQ-1:0]  r_s2_tag;
  logic [FLG_W-1:0] r_s2_flg;

  // Grants are masked during reset too, so every output reads 0 while it is held.
  assign w_arb_en = (r_state == ST_IDLE) && !cp0_pmp_wreq && !cpurst;

  ct_pmp_rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .i_clk (forever_cpuclk),
    .i_rst (cpurst),
    .i_en  (w_arb_en),
    .i_req (req_vld),
    .o_gnt (w_gnt)
  );

  assign req_gnt = w_gnt;

  always_comb begin
    w_gnt_pa   = '0;
    w_gnt_mprv = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_gnt_pa   = w_gnt_pa | req_pa[i*PA_W +: PA_W];
        w_gnt_mprv = w_gnt_mprv | req_mprv[i];
      end
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_s1_vld  <= 1'b0;
      r_s1_tag  <= '0;
      r_s1_pa   <= '0;
      r_s1_mprv <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_s2_tag  <= '0;
      r_s2_flg  <= '0;
    end else begin
      r_s1_vld  <= |w_gnt;
      r_s1_tag  <= w_gnt;
      r_s1_pa   <= w_gnt_pa;
      r_s1_mprv <= w_gnt_mprv;
      r_s2_vld  <= r_s1_vld;
      r_s2_tag  <= r_s1_tag;
      r_s2_flg  <= r_s1_vld ? acc_flg : '0;
    end
  end

  assign acc_pa          = r_s1_vld ? r_s1_pa : '0;
  assign acc_mprv_status = r_s1_vld & r_s1_mprv;
  assign rsp_vld         = r_s2_vld ? r_s2_tag : '0;
  assign rsp_flg         = r_s2_vld ? r_s2_flg : '0;

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // Only S1 reads the PMP registers; S2 already holds its flag, so draining S1 suffices.
  always_comb begin
    w_nxt_state  = r_state;
    pmp_cp0_wgnt = 1'b0;
    case (r_state)
      ST_IDLE:   if (cp0_pmp_wreq) w_nxt_state = ST_DRAIN;
      ST_DRAIN:  if (!r_s1_vld)    w_nxt_state = ST_WRITE;
      ST_WRITE: begin
        pmp_cp0_wgnt = 1'b1;
        w_nxt_state  = ST_SETTLE;
      end
      ST_SETTLE: w_nxt_state = ST_IDLE;
      default:   w_nxt_state = ST_IDLE;
    endcase
  end

endmodule

// File: doc/ct_pmp_chk_sched.md
Name: ct_pmp_chk_sched

Overview:
- Time-shares one ct_pmp_acc lookup port between NREQ physical-address requesters (IFU/LSU/PTW ports).
- Round-robin arbitration feeds a 2-stage check pipeline and returns a one-hot response with the 4-bit PMP flag.
- Sequences CP0 PMP CSR writes against in-flight checks, so no check ever sees a half-updated pmpcfg/pmpaddr set.

Parameters:
NREQ, 4, number of requesters (2..8)
PA_W, 28, physical address width presented to the checker
FLG_W, 4, PMP flag width returned by the checker

Ports:
forever_cpuclk  in  1  clock
cpurst  in  1  asynchronous reset, active-high
req_vld  in  NREQ  per-requester check request
req_pa  in  NREQ*PA_W  packed PA; requester i at [i*PA_W +: PA_W]
req_mprv  in  NREQ  per-requester MPRV status
req_gnt  out  NREQ  one-hot grant; request accepted this cycle
rsp_vld  out  NREQ  one-hot response valid
rsp_flg  out  FLG_W  PMP flag for the rsp_vld requester
acc_pa  out  PA_W  PA to the shared ct_pmp_acc
acc_mprv_status  out  1  MPRV status to ct_pmp_acc
acc_flg  in  FLG_W  ct_pmp_acc result (combinational from acc_pa)
cp0_pmp_wreq  in  1  CP0 requests a PMP CSR write; held until granted
pmp_cp0_wgnt  out  1  one-cycle write permission; CP0 asserts cp0_pmp_wreg only in this cycle

Behaviour:
Reset:
- All outputs 0.
- RR pointer = 0, so req 0 has highest priority.
- FSM in IDLE; S1/S2 valid cleared.
- Reset mid-operation drops in-flight checks; no rsp_vld for them.

Grant:
- Combinational.
- req_gnt[i]=1 only in FSM IDLE with cp0_pmp_wreq=0.
- Selects the first set req_vld at or after the RR pointer, wrapping modulo NREQ.
- At most one grant per cycle.
- On grant, the pointer moves to (granted index + 1) mod NREQ. Without a grant the pointer is held.
- A requester holds req_vld/req_pa until granted; its PA is not sampled otherwise.

Pipeline (no back-pressure; one check per cycle sustained):
- S1 (registered at the grant edge): vld, one-hot tag, pa, mprv. acc_pa = S1.pa and acc_mprv_status = S1.mprv; both are 0 when S1 is empty.
- S2 (registered from S1): vld, tag, flg = acc_flg.
- rsp_vld = S2.vld ? S2.tag : 0; rsp_flg = S2.flg (0 when S2 is empty).
- Latency: grant in cycle T gives rsp_vld in cycle T+2.

Write FSM (2-bit):
- IDLE: if cp0_pmp_wreq, go to DRAIN. No grant in that cycle; the write wins over simultaneous requests.
- DRAIN: no grants. If S1.vld=0, go to WRITE.
- WRITE: pmp_cp0_wgnt=1 for exactly this cycle; go to SETTLE.
- SETTLE: no grants; registers now hold the new value; go to IDLE.
- Timing: wreq in cycle T gives wgnt in T+2 and the first new grant in T+4 (if wreq has dropped).
- A check granted before T completes with the old configuration. A check granted after SETTLE sees the new one.
- Back-to-back wreq: SETTLE goes to IDLE, then IDLE immediately goes to DRAIN. Requests stall; no starvation guarantee against a continuous CSR write stream is required.
- S2 needs no drain: its flag is already captured.

Boundaries:
- All req_vld set: strict rotation, each requester granted once per NREQ grants.
- Single requester: granted every IDLE cycle.
- cp0_pmp_wreq asserted in DRAIN/WRITE/SETTLE: no effect beyond holding the sequence.

Decomposition:
- Shared package ct_pmp_pkg holds:
  - FSM state encoding: IDLE=2'b00, DRAIN=2'b01, WRITE=2'b10, SETTLE=2'b11.
  - Default PA_W/FLG_W constants.
- Sub-module ct_pmp_rr_arb: NREQ-wide round-robin arbiter with pointer register, req vector, enable input and one-hot grant output.
- Pipeline registers and FSM stay in the top.

Test Plan:
1. Reset, then req_vld=4'b0001 with pa=28'h0000123, acc_flg driven 4'b1011 from acc_pa -> req_gnt=4'b0001 at T; acc_pa=28'h0000123 at T+1; rsp_vld=4'b0001, rsp_flg=4'b1011 at T+2.
2. req_vld=4'b1111 held for 8 cycles from reset -> grant sequence 0,1,2,3,0,1,2,3; rsp_vld follows two cycles later with matching tags.
3. Grant req1 in cycle T-1, cp0_pmp_wreq=1 in T while req_vld=4'b0101 -> no grant in T..T+3; pmp_cp0_wgnt=1 only in T+2; req1 response in T+1 uses the old flag; next grant in T+4 goes to req2.
4. cp0_pmp_wreq and req_vld=4'b1000 rise in the same IDLE cycle -> req_gnt stays 0 and pmp_cp0_wgnt=1 two cycles later.
5. Assert cpurst with S1 and S2 both valid -> rsp_vld, req_gnt, pmp_cp0_wgnt and acc_pa are 0 immediately; after release, req_vld=4'b1010 gives the first grant to req1 (pointer reset to 0).
6. Single requester req_vld=4'b0100 held for 5 cycles -> 5 consecutive grants and 5 consecutive responses, no bubbles.
